// File: rtl/switch_bank.sv
`default_nettype none
// ============================================================================
// Module   : switch_bank
// Brief    : N-channel push-button front end: 2-flop sync, polarity fix,
//            debounce filter, registered press/release strobes and optional
//            auto-repeat (enabled by defining SWITCH_BANK_REPEAT_EN).
//            The release strobe port is named "released" because "release"
//            is a reserved word.
// Revision : 1.0 - initial release
// ============================================================================
module switch_bank #(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] level,
  output logic [NUM_SW-1:0] press,
  output logic [NUM_SW-1:0] released,
  output logic [NUM_SW-1:0] rpt,
  output logic              pushing
);

  localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_SW-1:0] c_pin_idle = {NUM_SW{ACTIVE_LOW}};

  logic [NUM_SW-1:0] r_sync1;
  logic [NUM_SW-1:0] r_sync2;
  logic [NUM_SW-1:0] w_s;

  // Sync flops idle at the released pin level so reset release never strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= c_pin_idle;
      r_sync2 <= c_pin_idle;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ c_pin_idle;

`ifdef SWITCH_BANK_REPEAT_EN
  localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rpt_w   = $clog2(c_rpt_max + 1);
  localparam logic [c_rpt_w-1:0] c_rpt_delay  = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_rpt_period = c_rpt_w'(REPEAT_PERIOD - 1);
`else
  logic [31:0] w_unused_rpt_cfg;
  assign w_unused_rpt_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_ch
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_level;
      logic               r_press;
      logic               r_rel;
      logic               w_accept;

      assign w_accept = (w_s[gi] != r_level) && (r_cnt == c_cnt_last);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_press <= 1'b0;
          r_rel   <= 1'b0;
        end else begin
          r_press <= w_accept & w_s[gi];
          r_rel   <= w_accept & ~w_s[gi];
          if ((w_s[gi] == r_level) || w_accept) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_accept) begin
            r_level <= w_s[gi];
          end
        end
      end

      assign level[gi]    = r_level;
      assign press[gi]    = r_press;
      assign released[gi] = r_rel;

`ifdef SWITCH_BANK_REPEAT_EN
      logic [c_rpt_w-1:0] r_rpt_cnt;
      logic               r_rpt;

      // An accepted release takes priority so no repeat lands in its cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rpt_cnt <= '0;
          r_rpt     <= 1'b0;
        end else begin
          r_rpt <= 1'b0;
          if (w_accept) begin
            r_rpt_cnt <= w_s[gi] ? c_rpt_delay : '0;
          end else if (r_level) begin
            if (r_rpt_cnt == '0) begin
              r_rpt     <= 1'b1;
              r_rpt_cnt <= c_rpt_period;
            end else begin
              r_rpt_cnt <= r_rpt_cnt - 1'b1;
            end
          end
        end
      end

      assign rpt[gi] = r_rpt;
`else
      assign rpt[gi] = 1'b0;
`endif
    end
  endgenerate

  assign pushing = |level;

endmodule
`default_nettype wire

// File: tb/tb_switch_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_bank
// Brief    : Scoreboard bench for switch_bank (4 channels, debounce 4,
//            repeat delay 8 / period 3); follows SWITCH_BANK_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_bank;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sw      = 4'b0000;
  logic [3:0] sw_al   = 4'b1111;

  logic [3:0] level, press, released, rpt;
  logic       pushing;
  logic [3:0] level_al, press_al, released_al, rpt_al;
  logic       pushing_al;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic al_seen = 1'b0;

  typedef struct packed {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] level;
  } ev_t;

  ev_t q[$];

  switch_bank #(
    .NUM_SW(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .level(level), .press(press),
    .released(released), .rpt(rpt), .pushing(pushing)
  );

  switch_bank #(
    .NUM_SW(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_al (
    .clk(clk), .reset_n(reset_n), .sw(sw_al), .level(level_al), .press(press_al),
    .released(released_al), .rpt(rpt_al), .pushing(pushing_al)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] t, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rpt = t; e.level = l;
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every strobe the DUT shows must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ((press | released | rpt) != 4'b0000)) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {press, released, rpt}, 32'h0);
        end else begin
          e = q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_press", press, e.press);
          chk("ev_release", released, e.rel);
          chk("ev_rpt", rpt, e.rpt);
          chk("ev_level", level, e.level);
        end
      end
      if ({level_al, press_al, released_al, rpt_al, pushing_al} != 17'h0) al_seen = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    int j;

    // Reset state, then idle after reset release on both polarities
    repeat (3) @(negedge clk);
    chk("rst_outputs", {level, press, released, rpt, pushing}, 32'h0);
    chk("rst_outputs_al", {level_al, press_al, released_al, rpt_al, pushing_al}, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {level, press, released, rpt, pushing}, 32'h0);
      chk("idle_outputs_al", {level_al, press_al, released_al, rpt_al, pushing_al}, 32'h0);
    end

    // Single press/hold/release on channel 0
    k = cyc;
    sw[0] = 1'b1;
    push(k + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef SWITCH_BANK_REPEAT_EN
    push(k + 14, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push(k + 17, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push(k + 20, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    push(k + 22, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    goto(k + 5);
    chk("level_before_latency", level, 4'b0000);
    goto(k + 6);
    chk("pushing_on_press", pushing, 1'b1);
    goto(k + 7);
    chk("level_held", level, 4'b0001);
    goto(k + 16);
    sw[0] = 1'b0;
    goto(k + 23);
    chk("level_after_release", level, 4'b0000);
    chk("pushing_after_release", pushing, 1'b0);

    // Glitch train on channel 1: 3 high, 1 low, 3 high
    k = cyc;
    sw[1] = 1'b1;
    goto(k + 3);
    sw[1] = 1'b0;
    goto(k + 4);
    sw[1] = 1'b1;
    goto(k + 7);
    sw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("glitch_level1", level[1], 1'b0);
    end

    // Channels 2 and 3 together, staggered release
    k = cyc;
    sw[3:2] = 2'b11;
    push(k + 6, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
`ifdef SWITCH_BANK_REPEAT_EN
    push(k + 14, 4'b0000, 4'b0000, 4'b1100, 4'b1100);
    push(k + 16, 4'b0000, 4'b0100, 4'b0000, 4'b1000);
    push(k + 17, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
`else
    push(k + 16, 4'b0000, 4'b0100, 4'b0000, 4'b1000);
`endif
    push(k + 20, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    goto(k + 6);
    chk("pushing_dual", pushing, 1'b1);
    goto(k + 10);
    sw[2] = 1'b0;
    goto(k + 14);
    sw[3] = 1'b0;
    goto(k + 17);
    chk("pushing_one_left", pushing, 1'b1);
    chk("level_one_left", level, 4'b1000);
    goto(k + 21);
    chk("pushing_all_released", pushing, 1'b0);

    // Asynchronous reset while held and mid-repeat, switch kept high
    k = cyc;
    sw[0] = 1'b1;
    push(k + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    goto(k + 10);
    chk("level_before_reset", level, 4'b0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {level, press, released, rpt, pushing}, 32'h0);
    goto(k + 13);
    j = cyc;
    push(j + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef SWITCH_BANK_REPEAT_EN
    push(j + 14, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    push(j + 16, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    goto(j + 5);
    chk("level_after_reset_latency", level, 4'b0000);
    goto(j + 10);
    sw[0] = 1'b0;
    goto(j + 26);

    chk("scoreboard_empty", q.size(), 0);
    chk("active_low_quiet", al_seen, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
